// File: rtl/mux_2x1_rr_buffered.sv
// ============================================================================
// Module      : mux_2x1_rr_buffered
// Description : Two-branch FIFO-buffered 2:1 mux with a registered output and
//               command-selected arbitration (round-robin, fixed, priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2x1_rr_buffered #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int COMMMAND_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*DATA_WIDTH-1:0]     i_data_bus,
    input  logic [1:0]                  i_valid,
    output logic [1:0]                  o_ready,
    output logic [DATA_WIDTH-1:0]       o_data_bus,
    output logic                        o_valid,
    output logic                        o_src,
    input  logic                        i_ready,
    input  logic                        i_en,
    input  logic [COMMMAND_WIDTH-1:0]   i_cmd
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);

    localparam logic [COMMMAND_WIDTH-1:0] c_CMD_LOW  = COMMMAND_WIDTH'(1);
    localparam logic [COMMMAND_WIDTH-1:0] c_CMD_HIGH = COMMMAND_WIDTH'(2);
    localparam logic [COMMMAND_WIDTH-1:0] c_CMD_PRIO = COMMMAND_WIDTH'(3);

    logic [1:0]              w_nempty;
    logic [1:0]              w_pop;
    logic [2*DATA_WIDTH-1:0] w_head_bus;
    logic [DATA_WIDTH-1:0]   w_head;
    logic                    w_have;
    logic                    w_sel;
    logic                    w_load;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_src;

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]    r_wr_ptr;
        logic [c_PTR_W-1:0]    r_rd_ptr;
        logic [c_CNT_W-1:0]    r_count;
        logic                  w_push;

        assign w_push = i_valid[k] & o_ready[k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
                    r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop[k]) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop[k]) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end

        // Ready comes only from registered occupancy, so downstream stalls never reach it.
        assign o_ready[k]  = (r_count != c_FULL);
        assign w_nempty[k] = (r_count != '0);
        assign w_head_bus[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr];
    end

    always_comb begin
        w_have = 1'b0;
        w_sel  = 1'b0;
        case (i_cmd)
            c_CMD_LOW: begin
                w_have = w_nempty[0];
                w_sel  = 1'b0;
            end
            c_CMD_HIGH: begin
                w_have = w_nempty[1];
                w_sel  = 1'b1;
            end
            c_CMD_PRIO: begin
                w_have = |w_nempty;
                w_sel  = w_nempty[1];
            end
            default: begin
                // Round-robin alternates only when both branches are waiting.
                w_have = |w_nempty;
                if (&w_nempty) begin
                    w_sel = ~r_last;
                end else begin
                    w_sel = w_nempty[1];
                end
            end
        endcase
    end

    assign w_load = i_en & (~r_valid | i_ready) & w_have;
    assign w_pop  = {w_load & w_sel, w_load & ~w_sel};
    assign w_head = w_sel ? w_head_bus[DATA_WIDTH +: DATA_WIDTH]
                          : w_head_bus[0 +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_src   <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_load) begin
            r_data  <= w_head;
            r_valid <= 1'b1;
            r_src   <= w_sel;
            r_last  <= w_sel;
        end else if (r_valid && i_ready) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end
    end

    assign o_data_bus = r_data;
    assign o_valid    = r_valid;
    assign o_src      = r_src;

endmodule

`default_nettype wire

// File: tb/tb_mux_2x1_rr_buffered.sv
// ============================================================================
// Module      : tb_mux_2x1_rr_buffered
// Description : Directed self-checking bench for mux_2x1_rr_buffered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_2x1_rr_buffered;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] lo_data;
    logic [DW-1:0] hi_data;
    logic [1:0]    i_valid;
    logic [1:0]    o_ready;
    logic [DW-1:0] o_data_bus;
    logic          o_valid;
    logic          o_src;
    logic          i_ready;
    logic          i_en;
    logic [1:0]    i_cmd;

    int n_cmp = 0;
    int n_err = 0;

    mux_2x1_rr_buffered #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (2),
        .COMMMAND_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data_bus ({hi_data, lo_data}),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data_bus (o_data_bus),
        .o_valid    (o_valid),
        .o_src      (o_src),
        .i_ready    (i_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic s, input logic [DW-1:0] d);
        check({tag, "_valid"}, 64'(o_valid), 64'(v));
        check({tag, "_src"},   64'(o_src),   64'(s));
        check({tag, "_data"},  64'(o_data_bus), 64'(d));
    endtask

    initial begin
        rst_n   = 1'b0;
        lo_data = '0;
        hi_data = '0;
        i_valid = 2'b00;
        i_ready = 1'b1;
        i_en    = 1'b1;
        i_cmd   = 2'b00;
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 32'h0);
        check("reset_ready", 64'(o_ready), 64'(2'b11));
        rst_n = 1'b1;
        tick();

        // Round-robin with both branches streaming together
        i_valid = 2'b11; lo_data = 32'hA0; hi_data = 32'hB0;
        tick();
        lo_data = 32'hA1; hi_data = 32'hB1;
        tick();
        i_valid = 2'b00;
        check_out("rr0", 1'b1, 1'b0, 32'hA0);
        tick();
        check_out("rr1", 1'b1, 1'b1, 32'hB0);
        tick();
        check_out("rr2", 1'b1, 1'b0, 32'hA1);
        tick();
        check_out("rr3", 1'b1, 1'b1, 32'hB1);
        tick();
        check_out("rr_empty", 1'b0, 1'b1, 32'h0);

        // Two-cycle latency, no bypass
        i_valid = 2'b10; hi_data = 32'h5A5A5A5A;
        tick();
        i_valid = 2'b00;
        check("lat_nobypass", 64'(o_valid), 64'(1'b0));
        tick();
        check_out("lat_word", 1'b1, 1'b1, 32'h5A5A5A5A);
        tick();
        check("lat_after_valid", 64'(o_valid), 64'(1'b0));
        check("lat_after_data", 64'(o_data_bus), 64'h0);

        // Backpressure on low branch
        i_ready = 1'b0;
        i_valid = 2'b01; lo_data = 32'h11;
        tick();
        lo_data = 32'h22;
        tick();
        lo_data = 32'h33;
        tick();
        i_valid = 2'b00;
        check_out("bp_hold1", 1'b1, 1'b0, 32'h11);
        check("bp_ready_full", 64'(o_ready), 64'(2'b10));
        tick();
        check_out("bp_hold2", 1'b1, 1'b0, 32'h11);
        i_ready = 1'b1;
        tick();
        check_out("bp_w2", 1'b1, 1'b0, 32'h22);
        check("bp_ready_free", 64'(o_ready), 64'(2'b11));
        tick();
        check_out("bp_w3", 1'b1, 1'b0, 32'h33);
        tick();
        check("bp_empty", 64'(o_valid), 64'(1'b0));

        // High-only mode: low fills and stalls, then round-robin drains it
        i_cmd = 2'b10;
        i_valid = 2'b11; lo_data = 32'hC0; hi_data = 32'hD0;
        tick();
        lo_data = 32'hC1; hi_data = 32'hD1;
        tick();
        check_out("hi0", 1'b1, 1'b1, 32'hD0);
        check("hi_lo_full", 64'(o_ready), 64'(2'b10));
        lo_data = 32'hC2; hi_data = 32'hD2;
        tick();
        check_out("hi1", 1'b1, 1'b1, 32'hD1);
        lo_data = 32'hC3; hi_data = 32'hD3;
        tick();
        i_valid = 2'b00;
        check_out("hi2", 1'b1, 1'b1, 32'hD2);
        tick();
        check_out("hi3", 1'b1, 1'b1, 32'hD3);
        tick();
        check("hi_empty", 64'(o_valid), 64'(1'b0));
        i_cmd = 2'b00;
        tick();
        check_out("drain_lo0", 1'b1, 1'b0, 32'hC0);
        tick();
        check_out("drain_lo1", 1'b1, 1'b0, 32'hC1);
        tick();
        check("drain_empty", 64'(o_valid), 64'(1'b0));

        // Strict priority to high
        i_cmd = 2'b11;
        i_valid = 2'b11; lo_data = 32'hE0; hi_data = 32'hF0;
        tick();
        i_valid = 2'b00;
        tick();
        check_out("prio_hi", 1'b1, 1'b1, 32'hF0);
        tick();
        check_out("prio_lo", 1'b1, 1'b0, 32'hE0);
        tick();
        check("prio_empty", 64'(o_valid), 64'(1'b0));
        i_cmd = 2'b00;

        // Enable gating, then reset mid-stream
        i_en = 1'b0;
        i_valid = 2'b10; hi_data = 32'h71;
        tick();
        hi_data = 32'h72;
        tick();
        i_valid = 2'b00;
        tick();
        check("en_off_valid", 64'(o_valid), 64'(1'b0));
        check("en_off_ready", 64'(o_ready), 64'(2'b01));
        i_en = 1'b1;
        tick();
        check_out("en_on", 1'b1, 1'b1, 32'h71);
        i_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1'b0, 1'b0, 32'h0);
        check("rst_mid_ready", 64'(o_ready), 64'(2'b11));
        tick();
        rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        check("post_rst_v0", 64'(o_valid), 64'(1'b0));
        tick();
        check("post_rst_v1", 64'(o_valid), 64'(1'b0));
        tick();
        check("post_rst_v2", 64'(o_valid), 64'(1'b0));

        // Normal operation after reset
        i_valid = 2'b01; lo_data = 32'h99;
        tick();
        i_valid = 2'b00;
        tick();
        check_out("post_rst_word", 1'b1, 1'b0, 32'h99);
        tick();
        check("post_rst_empty", 64'(o_valid), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
